// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch (IF) requester and the data (MEM-stage) requester.
// Data wins simultaneous requests. IF is guaranteed service after STARVE_MAX
// consecutive data grants taken while IF was waiting.
// Each access holds its strobe for MEM_LAT cycles. The owner then gets a
// one-cycle valid with registered read data.
// Optional build macro MISALIGN_CHK_EN: a granted request whose address is
// not word-aligned gets no memory access. Its valid and err pulse one cycle
// after the grant, with rdata 0. Without the macro err stays 0 and addresses
// go to memory unmodified.
module mem_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              if_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DATA} owner_t;

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            we_q, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic            rd_d, wr_d;
  logic            ifv_d, dv_d, err_d;
  logic [DATA_W-1:0] ifr_d, dr_d;
  logic            grant_data, grant_if, misalign;
  logic [ADDR_W-1:0] req_addr;

  // IF sees a stall whenever it is asking and not completing this cycle
  assign if_stall = if_req & ~if_valid;

  // Arbitration, access sequencing and output next-values
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    we_d       = we_q;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    ifv_d      = 1'b0;
    dv_d       = 1'b0;
    err_d      = 1'b0;
    ifr_d      = if_rdata;
    dr_d       = d_rdata;
    grant_data = 1'b0;
    grant_if   = 1'b0;
    misalign   = 1'b0;
    req_addr   = '0;

    unique case (state_q)
      IDLE: begin
        grant_data = d_req && !(if_req && (starve_q == STARVE_LIM));
        grant_if   = if_req && !grant_data;
        req_addr   = grant_data ? d_addr : if_addr;

        if (grant_data) begin
          if (if_req) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
          end else begin
            starve_d = '0;
          end
        end else if (grant_if) begin
          starve_d = '0;
        end

        if (grant_data || grant_if) begin
          owner_d = grant_data ? OWN_DATA : OWN_IF;
          we_d    = grant_data && d_we;
          cnt_d   = CNT_LOAD;
`ifdef MISALIGN_CHK_EN
          misalign = (req_addr[1:0] != 2'b00);
`endif
          if (misalign) begin
            // Rejected: report straight away, memory never touched
            state_d = DONE;
            err_d   = 1'b1;
            if (grant_data) begin
              dv_d = 1'b1;
              dr_d = '0;
            end else begin
              ifv_d = 1'b1;
              ifr_d = '0;
            end
          end else begin
            state_d = ACCESS;
            addr_d  = req_addr;
            if (grant_data) begin
              wdata_d = d_wdata;
            end
            rd_d = ~we_d;
            wr_d = we_d;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          // Last strobe cycle: memory data is valid now
          state_d = DONE;
          if (owner_q == OWN_DATA) begin
            dv_d = 1'b1;
            dr_d = we_q ? '0 : mem_rdata;
          end else begin
            ifv_d = 1'b1;
            ifr_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          rd_d  = ~we_q;
          wr_d  = we_q;
        end
      end

      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end

      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      starve_q  <= '0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      we_q      <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_rd    <= rd_d;
      mem_wr    <= wr_d;
      if_valid  <= ifv_d;
      d_valid   <= dv_d;
      err       <= err_d;
      if_rdata  <= ifr_d;
      d_rdata   <= dr_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (MEM_LAT=3, STARVE_MAX=3). Memory returns
// address ^ RD_KEY. Expected completions are queued as stimulus is applied
// and checked as valids appear.
module tb_mem_port_arbiter;

  localparam int unsigned L      = 3;
  localparam logic [31:0] RD_KEY = 32'h8C01_0014;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_valid, d_valid, err, if_stall, mem_rd, mem_wr;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] mon_got;
  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .DATA_W(32), .ADDR_W(32), .MEM_LAT(L), .STARVE_MAX(3)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .err(err), .if_stall(if_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory model: read data is a fixed function of the address
  assign mem_rdata = mem_addr ^ RD_KEY;

  // Scoreboard monitor: each valid must match the oldest queued expectation
  always @(negedge clock) begin
    if (reset && (if_valid || d_valid)) begin
      total++;
      if (if_valid && d_valid) begin
        bad++;
        $display("FAIL both_valid if_valid=%0b d_valid=%0b required one", if_valid, d_valid);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid if_valid=%0b d_valid=%0b required none", if_valid, d_valid);
      end else begin
        mon_e   = sb.pop_front();
        mon_got = d_valid ? d_rdata : if_rdata;
        if (d_valid !== mon_e.is_d) begin
          bad++;
          $display("FAIL sb_owner got_data=%0b required_data=%0b", d_valid, mon_e.is_d);
        end
        total++;
        if (mon_got !== mon_e.rdata) begin
          bad++;
          $display("FAIL sb_rdata got=%h required=%h", mon_got, mon_e.rdata);
        end
        total++;
        if (err !== mon_e.err) begin
          bad++;
          $display("FAIL sb_err got=%0b required=%0b", err, mon_e.err);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    cyc(); cyc();
    total++;
    if ({if_valid, d_valid, err, mem_rd, mem_wr, if_stall} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b required=000000",
               {if_valid, d_valid, err, mem_rd, mem_wr, if_stall});
    end
    total++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      bad++;
      $display("FAIL reset_data got=%h %h %h %h required zeros",
               if_rdata, d_rdata, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_if_read();
    if_req = 1; if_addr = 32'h10;
    sb.push_back('{1'b0, 32'h8C01_0004, 1'b0});
    for (int k = 1; k <= L + 1; k++) begin
      cyc();
      total++;
      if (mem_rd !== (k <= L) || mem_wr !== 1'b0) begin
        bad++;
        $display("FAIL if_strobe k=%0d rd=%0b wr=%0b required rd=%0b wr=0", k, mem_rd, mem_wr, k <= L);
      end
      if (k <= L) begin
        total++;
        if (mem_addr !== 32'h10) begin
          bad++;
          $display("FAIL if_addr k=%0d got=%h required=00000010", k, mem_addr);
        end
      end
      total++;
      if (if_valid !== (k == L + 1) || if_stall !== (k <= L)) begin
        bad++;
        $display("FAIL if_timing k=%0d valid=%0b stall=%0b required valid=%0b stall=%0b",
                 k, if_valid, if_stall, k == L + 1, k <= L);
      end
    end
    if_req = 0;
    cyc();
  endtask

  task automatic test_write();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b1, 32'h0, 1'b0});
    for (int k = 1; k <= L + 1; k++) begin
      cyc();
      total++;
      if (mem_wr !== (k <= L) || mem_rd !== 1'b0) begin
        bad++;
        $display("FAIL wr_strobe k=%0d wr=%0b rd=%0b required wr=%0b rd=0", k, mem_wr, mem_rd, k <= L);
      end
      if (k <= L) begin
        total++;
        if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h40) begin
          bad++;
          $display("FAIL wr_bus k=%0d addr=%h wdata=%h required 00000040 deadbeef", k, mem_addr, mem_wdata);
        end
      end
      total++;
      if (d_valid !== (k == L + 1)) begin
        bad++;
        $display("FAIL wr_valid k=%0d got=%0b required=%0b", k, d_valid, k == L + 1);
      end
    end
    d_req = 0; d_we = 0;
    cyc();
    total++;
    if (if_rdata !== 32'h8C01_0004) begin
      bad++;
      $display("FAIL wr_if_rdata_hold got=%h required=8c010004", if_rdata);
    end
    total++;
    if (mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL idle_bus_hold addr=%h wdata=%h required 00000040 deadbeef", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_simultaneous();
    logic exp_rd;
    if_req = 1; if_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h80;
    sb.push_back('{1'b1, 32'h80 ^ RD_KEY, 1'b0});
    sb.push_back('{1'b0, 32'h8C01_0004, 1'b0});
    for (int k = 1; k <= 2 * L + 3; k++) begin
      cyc();
      exp_rd = (k <= L) || (k >= L + 3 && k <= 2 * L + 2);
      total++;
      if (mem_rd !== exp_rd) begin
        bad++;
        $display("FAIL sim_strobe k=%0d got=%0b required=%0b", k, mem_rd, exp_rd);
      end
      if (exp_rd) begin
        total++;
        if (mem_addr !== ((k <= L) ? 32'h80 : 32'h10)) begin
          bad++;
          $display("FAIL sim_order k=%0d addr=%h required=%h", k, mem_addr, (k <= L) ? 32'h80 : 32'h10);
        end
      end
      total++;
      if (if_stall !== (k < 2 * L + 3) || d_valid !== (k == L + 1) || if_valid !== (k == 2 * L + 3)) begin
        bad++;
        $display("FAIL sim_timing k=%0d stall=%0b dv=%0b iv=%0b", k, if_stall, d_valid, if_valid);
      end
      if (k == L + 1) d_req = 0;
    end
    if_req = 0;
    cyc();
  endtask

  task automatic test_starvation();
    int nv;
    int ni;
    int k;
    if_req = 1; if_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h80;
    for (int g = 0; g < 8; g++) begin
      if ((g % 4) == 3) sb.push_back('{1'b0, 32'h8C01_0004, 1'b0});
      else              sb.push_back('{1'b1, 32'h80 ^ RD_KEY, 1'b0});
    end
    nv = 0; ni = 0; k = 0;
    while (nv < 8 && k < 8 * (L + 2) + 10) begin
      cyc();
      k++;
      if (if_valid || d_valid) begin
        nv++;
        if (if_valid) ni++;
        total++;
        if (k != nv * (L + 2) - 1) begin
          bad++;
          $display("FAIL starve_rate grant=%0d cycle=%0d required=%0d", nv, k, nv * (L + 2) - 1);
        end
      end
    end
    if_req = 0; d_req = 0;
    total++;
    if (nv != 8 || ni != 2) begin
      bad++;
      $display("FAIL starve_count valids=%0d if_valids=%0d required 8 and 2", nv, ni);
    end
    cyc(); cyc();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_addr = 32'h80;
    cyc(); cyc();
    total++;
    if (mem_rd !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_strobe got=%0b required=1", mem_rd);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({mem_rd, mem_wr, if_valid, d_valid, err} !== 5'b0) begin
      bad++;
      $display("FAIL mid_abort got=%b required=00000", {mem_rd, mem_wr, if_valid, d_valid, err});
    end
    d_req = 0;
    cyc(); cyc();
    reset = 1'b1;
    for (int k = 0; k < L + 3; k++) begin
      cyc();
      total++;
      if ({mem_rd, mem_wr, if_valid, d_valid} !== 4'b0) begin
        bad++;
        $display("FAIL mid_quiet k=%0d got=%b required=0000", k, {mem_rd, mem_wr, if_valid, d_valid});
      end
    end
    test_if_read();
  endtask

  task automatic test_misalign();
    d_req = 1; d_we = 0; d_addr = 32'h42;
`ifdef MISALIGN_CHK_EN
    sb.push_back('{1'b1, 32'h0, 1'b1});
    cyc();
    total++;
    if (d_valid !== 1'b1 || err !== 1'b1 || mem_rd !== 1'b0) begin
      bad++;
      $display("FAIL misalign_reject dv=%0b err=%0b rd=%0b required 1 1 0", d_valid, err, mem_rd);
    end
    d_req = 0;
    cyc();
    total++;
    if (mem_rd !== 1'b0 || d_valid !== 1'b0) begin
      bad++;
      $display("FAIL misalign_after rd=%0b dv=%0b required 0 0", mem_rd, d_valid);
    end
`else
    sb.push_back('{1'b1, 32'h42 ^ RD_KEY, 1'b0});
    for (int k = 1; k <= L + 1; k++) begin
      cyc();
      total++;
      if (mem_rd !== (k <= L) || err !== 1'b0 || d_valid !== (k == L + 1)) begin
        bad++;
        $display("FAIL misalign_pass k=%0d rd=%0b err=%0b dv=%0b", k, mem_rd, err, d_valid);
      end
      if (k <= L) begin
        total++;
        if (mem_addr !== 32'h42) begin
          bad++;
          $display("FAIL misalign_addr k=%0d got=%h required=00000042", k, mem_addr);
        end
      end
    end
    d_req = 0;
    cyc();
`endif
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_misalign();
    cyc(); cyc();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
